// File: rtl/dec_pkg.sv
// Shared definitions for the timed N-to-M decoder: FSM encoding,
// hold-counter width and the code-to-one-hot helper.
package dec_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int CNT_W  = 8;
  localparam int OH_MAX = 256;

  // Full-width one-hot of an 8-bit code; callers cast down to NUM_OUT bits.
  function automatic logic [OH_MAX-1:0] code2onehot(input logic [CNT_W-1:0] code);
    logic [OH_MAX-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/dec_hold_timer.sv
// 8-bit load/decrement hold counter with synchronous clear and zero flag.
module dec_hold_timer
  import dec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load, load beats decrement; never wraps below 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (load_i)                cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decoder_n_to_m_timed.sv
// Registered N-to-M one-hot decoder with valid/ready accept, programmable
// hold time and a guaranteed all-off cycle between decoded pulses.
// Optional: define DEC_OOR_ERR_EN to add the sticky out-of-range err port.
module decoder_n_to_m_timed
  import dec_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int NUM_OUT  = 4,
  parameter int HOLD_CYC = 1,
  parameter int ACT_LOW  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [SEL_W-1:0]   in_sel,
  output logic               in_ready,
  input  logic               clr,
  output logic [NUM_OUT-1:0] y,
  output logic               busy
`ifdef DEC_OOR_ERR_EN
  , output logic             err
`endif
);

  localparam logic [NUM_OUT-1:0] Y_IDLE    = (ACT_LOW != 0) ? {NUM_OUT{1'b1}} : {NUM_OUT{1'b0}};
  localparam logic [CNT_W-1:0]   LOAD_VAL  = CNT_W'(HOLD_CYC - 1);
  localparam logic [SEL_W:0]     NUM_OUT_X = (SEL_W+1)'(NUM_OUT);

  state_e             state_q, state_d;
  logic [NUM_OUT-1:0] y_q, y_d;
  logic               rdy_en_q;
  logic               accept, in_range;
  logic               t_load, t_dec, t_zero;

  // in_ready stays low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  assign in_ready = rdy_en_q && (state_q == IDLE) && !clr;
  assign accept   = in_valid && in_ready;
  assign in_range = ({1'b0, in_sel} < NUM_OUT_X);
  assign busy     = (state_q == HOLD);
  assign y        = y_q;

  // Next-state / decode: clr aborts, accept loads the line, hold expiry releases it.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr) begin
          y_d = Y_IDLE;
        end else if (accept && in_range) begin
          y_d     = NUM_OUT'(code2onehot(CNT_W'(in_sel))) ^ Y_IDLE;
          t_load  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (clr || t_zero) begin
          y_d     = Y_IDLE;
          state_d = IDLE;
        end else begin
          t_dec = 1'b1;
        end
      end
      default: begin
        y_d     = Y_IDLE;
        state_d = IDLE;
      end
    endcase
  end

  // State and decode registers; reset drops the line immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= Y_IDLE;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  dec_hold_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (t_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (t_dec),
    .clr_i      (clr),
    .zero_o     (t_zero)
  );

`ifdef DEC_OOR_ERR_EN
  logic err_q;

  // Sticky out-of-range flag; only reset clears it, clr does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     err_q <= 1'b0;
    else if (accept && !in_range)   err_q <= 1'b1;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_decoder_n_to_m_timed.sv
// Bench: two decoders (active-high HOLD=3, active-low HOLD=1) on shared inputs,
// a cycle-level model of remaining hold cycles, directed literal checks and
// a randomized phase.
module tb_decoder_n_to_m_timed;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] in_sel = '0;
  logic [5:0] y0, y1;
  logic       rdy0, rdy1, busy0, busy1;
  logic       err0, err1;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  decoder_n_to_m_timed #(.SEL_W(3), .NUM_OUT(6), .HOLD_CYC(3), .ACT_LOW(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sel(in_sel),
    .in_ready(rdy0), .clr(clr), .y(y0), .busy(busy0)
`ifdef DEC_OOR_ERR_EN
    , .err(err0)
`endif
  );

  decoder_n_to_m_timed #(.SEL_W(3), .NUM_OUT(6), .HOLD_CYC(1), .ACT_LOW(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sel(in_sel),
    .in_ready(rdy1), .clr(clr), .y(y1), .busy(busy1)
`ifdef DEC_OOR_ERR_EN
    , .err(err1)
`endif
  );

`ifndef DEC_OOR_ERR_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hl = number of cycles the decoded line still has to be shown.
  int hl   [2];
  int line [2];
  bit er   [2];
  bit st   [2];

  function automatic int hc(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        hl[i] <= 0;
        er[i] <= 1'b0;
        st[i] <= 1'b0;
      end else begin
        st[i] <= 1'b1;
        if (clr)
          hl[i] <= 0;
        else if (hl[i] > 0)
          hl[i] <= hl[i] - 1;
        else if (in_valid && st[i]) begin
          if (int'(in_sel) < 6) begin
            hl[i]   <= hc(i);
            line[i] <= int'(in_sel);
          end else
            er[i] <= 1'b1;
        end
      end
    end
  end

  function automatic logic [5:0] expy(input int i);
    logic [5:0] v;
    v = (hl[i] > 0) ? (6'd1 << line[i]) : 6'd0;
    if (i == 1) v = ~v;
    return v;
  endfunction

  // Compare process: every falling edge, DUT outputs vs. model.
  always @(negedge clk) begin
    chk("y0",    32'(y0),    32'(expy(0)));
    chk("y1",    32'(y1),    32'(expy(1)));
    chk("busy0", 32'(busy0), 32'(hl[0] > 0));
    chk("busy1", 32'(busy1), 32'(hl[1] > 0));
    chk("rdy0",  32'(rdy0),  32'(st[0] && hl[0] == 0 && !clr));
    chk("rdy1",  32'(rdy1),  32'(st[1] && hl[1] == 0 && !clr));
`ifdef DEC_OOR_ERR_EN
    chk("err0",  32'(err0),  32'(er[0]));
    chk("err1",  32'(err1),  32'(er[1]));
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_y0",   32'(y0),   32'h00);
    chk("rst_y1",   32'(y1),   32'h3f);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_rdy",  32'(rdy0), 32'd0);
    #11 rst_n = 1'b1;
    cyc();
    chk("rdy_after_rst", 32'(rdy0), 32'd1);

    // single accept of code 5
    in_valid = 1'b1; in_sel = 3'd5;
    cyc();
    in_valid = 1'b0;
    chk("t1_y1_low", 32'(y1), 32'h1f);
    for (int k = 0; k < 3; k++) begin
      chk("t1_y0",   32'(y0),    32'h20);
      chk("t1_busy", 32'(busy0), 32'd1);
      if (k == 1) chk("t1_y1_off", 32'(y1), 32'h3f);
      cyc();
    end
    chk("t1_y0_off", 32'(y0),    32'h00);
    chk("t1_rdy",    32'(rdy0),  32'd1);
    chk("t1_idle",   32'(busy0), 32'd0);
    repeat (4) cyc();

    // back-to-back with valid held high
    in_valid = 1'b1; in_sel = 3'd2;
    cyc();
    in_sel = 3'd4;
    for (int k = 0; k < 3; k++) begin
      chk("t2_y0_a", 32'(y0), 32'h04);
      if (k == 0) chk("t2_rdy_hold", 32'(rdy0), 32'd0);
      cyc();
    end
    chk("t2_gap",     32'(y0),   32'h00);
    chk("t2_gap_rdy", 32'(rdy0), 32'd1);
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t2_y0_b", 32'(y0), 32'h10);
      cyc();
    end
    chk("t2_end", 32'(y0), 32'h00);
    repeat (4) cyc();

    // out-of-range code
    in_valid = 1'b1; in_sel = 3'd7;
    chk("t3_rdy", 32'(rdy0), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("t3_y0",   32'(y0),    32'h00);
    chk("t3_busy", 32'(busy0), 32'd0);
    chk("t3_rdy2", 32'(rdy0),  32'd1);
`ifdef DEC_OOR_ERR_EN
    chk("t3_err", 32'(err0), 32'd1);
`endif
    in_valid = 1'b1; in_sel = 3'd1;
    cyc();
    in_valid = 1'b0;
    chk("t3_y0_valid", 32'(y0), 32'h02);
`ifdef DEC_OOR_ERR_EN
    chk("t3_err_sticky", 32'(err0), 32'd1);
`endif
    repeat (4) cyc();

    // clr mid-hold, then clr together with valid
    in_valid = 1'b1; in_sel = 3'd1;
    cyc();
    in_valid = 1'b0;
    chk("t4_y0_c1", 32'(y0), 32'h02);
    cyc();
    chk("t4_y0_c2", 32'(y0), 32'h02);
    clr = 1'b1;
    chk("t4_rdy_clr", 32'(rdy0), 32'd0);
    cyc();
    chk("t4_y0_clr", 32'(y0),    32'h00);
    chk("t4_busy",   32'(busy0), 32'd0);
    in_valid = 1'b1; in_sel = 3'd3;
    chk("t4_rdy_clr2", 32'(rdy0), 32'd0);
    cyc();
    chk("t4_noacc_y", 32'(y0),    32'h00);
    chk("t4_noacc_b", 32'(busy0), 32'd0);
    clr = 1'b0; in_valid = 1'b0;
    cyc();
    chk("t4_still_off", 32'(y0), 32'h00);
    repeat (3) cyc();

    // async reset mid-hold
    in_valid = 1'b1; in_sel = 3'd4;
    cyc();
    in_valid = 1'b0;
    chk("t5_y0_on", 32'(y0), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_y0",  32'(y0),    32'h00);
    chk("t5_async_y1",  32'(y1),    32'h3f);
    chk("t5_async_bsy", 32'(busy0), 32'd0);
    #3 rst_n = 1'b1;
    cyc();
    chk("t5_rdy", 32'(rdy0), 32'd1);
`ifdef DEC_OOR_ERR_EN
    chk("t5_err", 32'(err0), 32'd0);
`endif

    // active-low, HOLD_CYC=1, code 0
    in_valid = 1'b1; in_sel = 3'd0;
    cyc();
    in_valid = 1'b0;
    chk("t6_y1_on",  32'(y1), 32'h3e);
    cyc();
    chk("t6_y1_off", 32'(y1), 32'h3f);
    repeat (3) cyc();

    // randomized traffic checked by the compare process
    for (int n = 0; n < 1500; n++) begin
      in_valid = ($urandom_range(0, 9) < 6);
      in_sel   = 3'($urandom_range(0, 7));
      clr      = ($urandom_range(0, 15) == 0);
      cyc();
    end
    in_valid = 1'b0; clr = 1'b0;
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
